// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and helpers for the instruction cache
package icache_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [127:0] lc3b_c_line;
    typedef logic [3:0]   lc3b_c_offset;

    localparam int ICACHE_LINE_BYTES = 16;
    localparam int ICACHE_OFFSET_W   = $clog2(ICACHE_LINE_BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } icache_state_e;

    // Word k of a line lives at bits [16k+15:16k].
    function automatic lc3b_word line_word(input lc3b_c_line line, input logic [2:0] sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_control.sv
// rtl/icache_control.sv - IDLE/FILL sequencer, miss capture and response decode
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_read, mem_write   CPU request strobes
//   hit                   lookup result for the current request address
//   req_tag, req_index    tag/index of the current request address
//   pmem_resp             fill data valid pulse from physical memory
//   mem_resp              completion pulse to the CPU (write ack or read hit)
//   hit_event             read hit being answered this cycle
//   miss_event            read miss being accepted this cycle
//   pmem_read             registered fill request
//   pmem_address          registered line-aligned fill address
//   fill_we               install the returned line this cycle
//   fill_index, fill_tag  where/what to install, captured at miss entry
module icache_control
    import icache_pkg::*;
#(
    parameter int IW = 3,
    parameter int TW = 16 - ICACHE_OFFSET_W - IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          hit,
    input  logic [TW-1:0] req_tag,
    input  logic [IW-1:0] req_index,
    input  logic          pmem_resp,
    output logic          mem_resp,
    output logic          hit_event,
    output logic          miss_event,
    output logic          pmem_read,
    output lc3b_word      pmem_address,
    output logic          fill_we,
    output logic [IW-1:0] fill_index,
    output logic [TW-1:0] fill_tag
);

    icache_state_e state_q;
    logic          pmem_read_q;
    lc3b_word      pmem_address_q;
    logic [IW-1:0] index_q;
    logic [TW-1:0] tag_q;
    logic          idle;
    logic          write_ack;

    // Everything is qualified with !reset so a reset cycle neither answers
    // nor installs anything, regardless of what else is happening.
    always_comb begin
        idle       = (state_q == ST_IDLE) && !reset;
        write_ack  = idle && mem_write;
        hit_event  = idle && !mem_write && mem_read && hit;
        miss_event = idle && !mem_write && mem_read && !hit;
        mem_resp   = write_ack || hit_event;
        fill_we    = (state_q == ST_FILL) && pmem_resp && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pmem_read_q    <= 1'b0;
            pmem_address_q <= '0;
            index_q        <= '0;
            tag_q          <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_event) begin
                        state_q        <= ST_FILL;
                        tag_q          <= req_tag;
                        index_q        <= req_index;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {req_tag, req_index, 4'b0000};
                    end
                end
                ST_FILL: begin
                    // The fill runs to completion even if the CPU drops or
                    // changes its request; the captured tag/index are used.
                    if (pmem_resp) begin
                        state_q     <= ST_IDLE;
                        pmem_read_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_address = pmem_address_q;
    assign fill_index   = index_q;
    assign fill_tag     = tag_q;

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - read-only direct-mapped instruction cache with hit/miss counters
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   mem_read/mem_write               CPU request (writes are acknowledged only)
//   mem_byte_enable, mem_wdata       ignored
//   mem_address                      CPU byte address
//   mem_resp, mem_rdata              one-cycle completion pulse and read word
//   pmem_read, pmem_address          line-fill request to physical memory
//   pmem_resp, pmem_rdata            fill data pulse and 128-bit line
//   hit_count, miss_count            saturating performance counters
module icache
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          pmem_read,
    output lc3b_word      pmem_address,
    input  logic          pmem_resp,
    input  lc3b_c_line    pmem_rdata,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 16 - ICACHE_OFFSET_W - IW;

    logic [NUM_SETS-1:0] valid_q;
    logic [TW-1:0]       tag_q  [NUM_SETS];
    lc3b_c_line          data_q [NUM_SETS];

    logic [15:0]   hit_count_q;
    logic [15:0]   miss_count_q;

    lc3b_c_offset  offset;
    logic [IW-1:0] req_index;
    logic [TW-1:0] req_tag;
    logic          hit;
    logic          hit_event;
    logic          miss_event;
    logic          fill_we;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic          unused_inputs;

    assign offset    = mem_address[3:0];
    assign req_index = mem_address[ICACHE_OFFSET_W +: IW];
    assign req_tag   = mem_address[15 -: TW];
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);

    // Byte lane inside a word does not matter for instruction fetch.
    assign unused_inputs = ^{mem_byte_enable, mem_wdata, offset[0]};

    icache_control #(
        .IW(IW),
        .TW(TW)
    ) u_control (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .req_tag      (req_tag),
        .req_index    (req_index),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .hit_event    (hit_event),
        .miss_event   (miss_event),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .fill_we      (fill_we),
        .fill_index   (fill_index),
        .fill_tag     (fill_tag)
    );

    // Data is only driven while a read hit is being answered.
    assign mem_rdata = hit_event ? line_word(data_q[req_index], offset[3:1]) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_index] <= pmem_rdata;
            tag_q[fill_index]  <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit_event && (hit_count_q != 16'hFFFF)) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (miss_event && (miss_count_q != 16'hFFFF)) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for the instruction cache
module tb_icache;

    logic          clk;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_byte_enable;
    logic [15:0]   mem_address;
    logic [15:0]   mem_wdata;
    logic          mem_resp;
    logic [15:0]   mem_rdata;
    logic          pmem_read;
    logic [15:0]   pmem_address;
    logic          pmem_resp;
    logic [127:0]  pmem_rdata;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    icache #(.NUM_SETS(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_address    (pmem_address),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pmem_cycles = 0;
    logic [15:0] last_paddr = 16'h0;
    logic        sb_off = 1'b0;
    logic        pmem_en = 1'b1;
    logic        stray = 1'b0;
    logic [15:0] stray_addr = 16'h0;
    int          pmem_lat = 3;

    // Memory image: word k of the line at A is A + k.
    function automatic logic [127:0] line_for(input logic [15:0] a);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = a + 16'(k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Physical memory responder.
    initial begin : pmem_model
        int cnt;
        cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray) begin
                pmem_resp = 1'b1;
                pmem_rdata = line_for(stray_addr);
                @(negedge clk);
                pmem_resp = 1'b0;
            end else if (pmem_read && pmem_en) begin
                cnt++;
                if (cnt == pmem_lat) begin
                    pmem_resp = 1'b1;
                    pmem_rdata = line_for(pmem_address);
                    @(negedge clk);
                    pmem_resp = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every response pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (pmem_read) begin
            pmem_cycles++;
            last_paddr = pmem_address;
        end
        if (mem_resp && !sb_off) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp actual=resp@%h rdata=%h required=no response", mem_address, mem_rdata);
            end else begin
                e = exp_q.pop_front();
                if (e.wr) chk("write_ack", 32'(mem_write), 32'd1);
                else      chk("resp_rdata", 32'(mem_rdata), 32'(e.data));
            end
        end
    end

    // Entered and left at posedge+1; leaves mem_read high for back-to-back use.
    task automatic do_read(input logic [15:0] a, input logic [15:0] expd);
        exp_t e;
        logic got;
        e.wr = 1'b0;
        e.data = expd;
        exp_q.push_back(e);
        mem_read = 1'b1;
        mem_address = a;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_resp) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL read_timeout actual=no resp addr=%h required=resp", a);
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int pc;
        exp_t e;
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 2'b11;
        mem_address = 16'h0;
        mem_wdata = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_resp", 32'(mem_resp), 0);
        chk("rst_pmem_read", 32'(pmem_read), 0);
        chk("rst_pmem_addr", 32'(pmem_address), 0);
        chk("rst_rdata", 32'(mem_rdata), 0);
        chk("rst_hits", 32'(hit_count), 0);
        chk("rst_misses", 32'(miss_count), 0);
        @(posedge clk);
        #1;

        // Cold miss
        pmem_cycles = 0;
        do_read(16'h0000, 16'h0000);
        chk("cold_pmem_cycles", 32'(pmem_cycles), 3);
        chk("cold_paddr", 32'(last_paddr), 32'h0000);
        chk("cold_misses", 32'(miss_count), 1);
        chk("cold_hits", 32'(hit_count), 1);

        // Sequential hits, back to back
        do_read(16'h0002, 16'h0001);
        do_read(16'h0004, 16'h0002);
        do_read(16'h000E, 16'h0007);
        mem_read = 1'b0;
        chk("seq_pmem_cycles", 32'(pmem_cycles), 3);
        chk("seq_hits", 32'(hit_count), 4);

        // Conflict eviction on index 0
        do_read(16'h0080, 16'h0080);
        chk("conf_paddr", 32'(last_paddr), 32'h0080);
        do_read(16'h0000, 16'h0000);
        mem_read = 1'b0;
        chk("conf_paddr2", 32'(last_paddr), 32'h0000);
        chk("conf_misses", 32'(miss_count), 3);

        // Miss then stall: fill completes without a response
        mem_read = 1'b1;
        mem_address = 16'h0130;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_address = 16'h0550;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_paddr", 32'(last_paddr), 32'h0130);
        chk("stall_misses", 32'(miss_count), 4);
        chk("stall_pmem_idle", 32'(pmem_read), 0);
        pc = pmem_cycles;
        do_read(16'h0130, 16'h0130);
        mem_read = 1'b0;
        chk("stall_refetch_nofill", 32'(pmem_cycles), 32'(pc));
        chk("stall_refetch_misses", 32'(miss_count), 4);
        chk("stall_refetch_hits", 32'(hit_count), 7);

        // Write ack, then odd address
        e.wr = 1'b1;
        e.data = 16'h0;
        exp_q.push_back(e);
        mem_write = 1'b1;
        mem_address = 16'h0010;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        chk("wr_hits", 32'(hit_count), 7);
        chk("wr_misses", 32'(miss_count), 4);
        @(posedge clk);
        #1;
        do_read(16'h0003, 16'h0001);
        do_read(16'h0002, 16'h0001);
        mem_read = 1'b0;
        chk("odd_hits", 32'(hit_count), 9);

        // Reset during a fill, then a stray pmem_resp
        pmem_en = 1'b0;
        mem_read = 1'b1;
        mem_address = 16'h0200;
        repeat (3) @(posedge clk);
        #1;
        chk("rf_in_fill", 32'(pmem_read), 1);
        reset = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rf_pmem_read", 32'(pmem_read), 0);
        chk("rf_pmem_addr", 32'(pmem_address), 0);
        chk("rf_misses", 32'(miss_count), 0);
        chk("rf_hits", 32'(hit_count), 0);
        @(posedge clk);
        #1;
        stray_addr = 16'h0200;
        stray = 1'b1;
        @(negedge clk);
        #1;
        stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pmem_en = 1'b1;
        do_read(16'h0200, 16'h0200);
        chk("rf_next_read_misses", 32'(miss_count), 1);
        chk("rf_next_read_paddr", 32'(last_paddr), 32'h0200);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 0);

        // Saturation: hold a hitting read for more than 65535 cycles
        sb_off = 1'b1;
        mem_read = 1'b1;
        mem_address = 16'h0200;
        repeat (65540) @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("sat_hits", 32'(hit_count), 32'hFFFF);
        chk("sat_misses", 32'(miss_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Read-only, direct-mapped instruction cache that answers the fetch stage's icache memory interface.
- It is the responder side of the fetch stage's request/response protocol: mem_read/mem_address in, one-cycle mem_resp pulse with mem_rdata out.
- On a miss it fills a 128-bit line from physical memory over a pmem read handshake, then serves the hit.
- It keeps saturating hit and miss counters for performance analysis.

Parameters:
- NUM_SETS, 8, number of lines; power of two, >= 2. Index width IW = log2(NUM_SETS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  CPU read request; held high until mem_resp.
- mem_write  in  1  CPU write request; unsupported, acknowledged only.
- mem_byte_enable  in  2  ignored.
- mem_address  in  16  CPU byte address (lc3b_word).
- mem_wdata  in  16  ignored.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  16  instruction word; valid when mem_resp=1.
- pmem_read  out  1  line-fill request to physical memory.
- pmem_address  out  16  line-aligned fill address (low 4 bits zero).
- pmem_resp  in  1  fill data valid, single-cycle pulse.
- pmem_rdata  in  128  fill line, word k at bits [16k+15:16k].
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Address split: offset = addr[3:0]; word select = addr[3:1]; addr[0] is ignored; index = addr[4+IW-1:4]; tag = addr[15:4+IW].
- Storage: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS] of 128 bits, all flops, read asynchronously.
- hit = valid[index] && tag[index] == addr tag.

States:
- IDLE:
  - mem_read && hit: mem_resp=1 combinationally in the same cycle; mem_rdata = data[index] word[addr[3:1]]. Hit latency is therefore 0 extra cycles (the response is sampled by the fetch stage at the next posedge). hit_count increments.
  - mem_read && !hit: go to FILL; miss_count increments (once per miss); mem_resp=0.
  - mem_write (with or without mem_read): mem_resp=1 for one cycle, no state change, no counter change. Write takes priority over read.
  - Otherwise: mem_resp=0.
- FILL:
  - pmem_read=1; pmem_address = {captured tag, captured index, 4'b0}, using the tag and index registered on miss entry.
  - On pmem_resp: write the data, tag, and valid=1 for the captured index; go to IDLE.
  - mem_resp=0 throughout FILL. The retried read then hits on the cycle after return to IDLE (miss latency = pmem latency + 1 cycle + hit).
- The fill always completes even if mem_read drops (fetch stalled) or mem_address changes mid-fill; the line is installed regardless.
- pmem_resp while in IDLE is ignored.
- Never more than one mem_resp per request cycle: after a hit, if mem_read stays high with a new address, that address is evaluated fresh in the following cycle.
- Counters saturate at 16'hFFFF; no wrap-around.

Reset (synchronous):
- All valid bits cleared; state=IDLE; counters=0.
- Outputs after reset: mem_resp=0, pmem_read=0, pmem_address=0, mem_rdata=0 while not responding.
- Reset during FILL abandons the fill: no line is written, and a later stray pmem_resp is ignored.
- Reset has priority over every other event in the same cycle.

Decomposition:
- lc3b_types gains:
  - lc3b_c_line (128 bits)
  - lc3b_c_offset (4 bits)
  - constant ICACHE_LINE_BYTES = 16
- Existing lc3b_word and lc3b_mem_wmask are reused.
- One natural sub-module: icache_control, holding the IDLE/FILL FSM, miss capture registers, and the mem_resp/pmem_read decode. Arrays, hit compare, and word mux stay in icache.

Test Plan:
- Cold miss: reset, then mem_read=1, addr=16'h0000; pmem_resp after 3 cycles with line 16'h0007..16'h0000 (word k = k) -> pmem_read high 3 cycles at pmem_address 16'h0000; mem_resp pulses once with mem_rdata=16'h0000; miss_count=1, hit_count=1.
- Sequential hits: after the fill, addresses 16'h0002, 16'h0004, 16'h000E -> mem_resp every cycle with data 1, 2, 7; no pmem_read; hit_count=4.
- Conflict eviction (NUM_SETS=8): read 16'h0080 (same index 0, different tag) -> miss with pmem_address=16'h0080; a subsequent read of 16'h0000 misses again; miss_count=3.
- Stall mid-fill: miss on 16'h0130, drop mem_read for 5 cycles while pmem_resp arrives -> line installed, no mem_resp; reasserting 16'h0130 hits immediately.
- Write / odd address: mem_write=1 at 16'h0010 -> mem_resp=1 one cycle, counters unchanged. Read of 16'h0003 -> returns the same word as 16'h0002.
- Reset mid-fill, then saturation:
  - Reset asserted during FILL, then a late pmem_resp -> valid stays 0 and the next read misses.
  - Forcing 65536 hits -> hit_count holds at 16'hFFFF.
